// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding
// and default parameter values used by uart_tx_sched and its arbiter.
package uart_sched_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans the request vector starting at
// index ptr (wrapping modulo N) and returns the first active requester as
// a one-hot grant plus its binary index. any is high when a winner exists.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // First set request at or after ptr, wrapping once around the vector.
    always_comb begin
        int k;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = 0;
        for (int off = 0; off < N; off++) begin
            k = int'(ptr) + off;
            if (k >= N) begin
                k = k - N;
            end
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ
// requesters. A grant registers the winner's byte into tx_data, then a
// one-cycle START state pulses tx_start and the winner's req_ready, after
// which the FSM tracks the transmitter's busy flag up and back down.
//
// Handshake: a requester holds req_valid/req_data until it sees its
// req_ready pulse; req_valid is only looked at while the FSM is IDLE, so
// a requester may drop it at any time before being granted.
//
// Optional build macro UART_SCHED_TIMEOUT_EN adds a watchdog on WAIT_BUSY
// that returns to IDLE and sets the sticky timeout_err flag if the
// transmitter never reports busy within TIMEOUT_CYCLES cycles.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter  int NUM_REQ        = DEF_NUM_REQ,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [IDX_W-1:0]     cur_owner,
    output logic                 sched_busy,
    output logic                 timeout_err,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] IDLE      = S_IDLE;
    localparam logic [1:0] START     = S_START;
    localparam logic [1:0] WAIT_BUSY = S_WAIT_BUSY;
    localparam logic [1:0] WAIT_DONE = S_WAIT_DONE;

    // Reject out-of-range configurations at elaboration time.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_sched: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("uart_tx_sched: TIMEOUT_CYCLES must be 1..255");
    end

    logic [1:0]         state;
    logic [IDX_W-1:0]   rr_ptr;      // first index scanned at the next grant
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] grant_q;     // winner held for the START pulse
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic [7:0]         win_data;
    logic [IDX_W-1:0]   next_ptr;
    logic               wd_expired;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant_oh),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    assign win_data = req_data[{grant_idx, 3'b000} +: 8];
    assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Main scheduler FSM with grant capture; the pointer moves past each winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            tx_data   <= 8'h00;
            cur_owner <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any && !tx_busy) begin
                        tx_data   <= win_data;
                        cur_owner <= grant_idx;
                        grant_q   <= grant_oh;
                        rr_ptr    <= next_ptr;
                        state     <= START;
                    end
                end
                START: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wd_expired) begin
                        state <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       timeout_q;

    assign wd_expired  = (state == WAIT_BUSY) && !tx_busy &&
                         (wd_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign timeout_err = timeout_q;

    // Watchdog counts cycles spent in WAIT_BUSY and clears on leaving it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt    <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            if (state == WAIT_BUSY && !tx_busy && !wd_expired) begin
                wd_cnt <= wd_cnt + 8'h01;
            end else begin
                wd_cnt <= 8'h00;
            end
            if (wd_expired) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign req_ready  = (state == START) ? grant_q : '0;
    assign tx_start   = (state == START);
    assign sched_busy = (state != IDLE);
    assign state_dbg  = state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched. Requesters are modelled as byte
// queues; a reference model predicts the grant order of each batch of
// requests from round-robin rules and queues {owner, byte} expectations,
// which a monitor pops whenever the DUT pulses tx_start/req_ready.
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int NUM_REQ = 4;
    localparam int TOUT    = 5;
    localparam int IW      = 2;
    localparam int EW      = 3 + 8;

    typedef struct {
        int         op;    // 0 = enqueue byte, 1 = withdraw requester
        int         idx;
        logic [7:0] data;
    } cmd_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [IW-1:0]        cur_owner;
    logic                 sched_busy;
    logic                 timeout_err;
    logic [1:0]           state_dbg;
    logic                 uart_busy = 1'b0;
    logic                 man_busy = 1'b0;
    logic                 uart_auto = 1'b0;
    logic                 rst_q;

    logic [EW-1:0] exp_q[$];
    int            grant_log[$];
    cmd_t          new_q[$];
    int            checks = 0;
    int            errors = 0;
    int            model_last = NUM_REQ - 1;
    int            b_cnt[NUM_REQ];
    logic [7:0]    b_dat[NUM_REQ][4];
    logic [7:0]    rbuf[NUM_REQ][16];
    int            rhead[NUM_REQ];
    int            rcnt[NUM_REQ];
    logic [7:0]    hold_data = 8'h00;

    assign tx_busy = uart_busy | man_busy;

    // Clock and reset sampling
    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst;

    uart_tx_sched #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .cur_owner   (cur_owner),
        .sched_busy  (sched_busy),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_batch();
        for (int i = 0; i < NUM_REQ; i++) begin
            b_cnt[i] = 0;
        end
    endtask

    // Reference model: send the batch to the requesters and predict the
    // grant sequence as rotating rounds over requesters with bytes left.
    task automatic issue_batch();
        int   rem[NUM_REQ];
        int   pos[NUM_REQ];
        int   total;
        int   base;
        int   k;
        cmd_t c;
        total = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rem[i] = b_cnt[i];
            pos[i] = 0;
            total += b_cnt[i];
            for (int j = 0; j < b_cnt[i]; j++) begin
                c.op = 0; c.idx = i; c.data = b_dat[i][j];
                new_q.push_back(c);
            end
        end
        base = model_last;
        while (total > 0) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                k = (base + off) % NUM_REQ;
                if (rem[k] > 0) begin
                    exp_q.push_back({3'(k), b_dat[k][pos[k]]});
                    pos[k]++;
                    rem[k]--;
                    total--;
                    model_last = k;
                end
            end
            base = model_last;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        model_last = NUM_REQ - 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_tx_data"}, tx_data, 8'h00);
        check({tag, "_cur_owner"}, cur_owner, 0);
        check({tag, "_sched_busy"}, sched_busy, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (tx_start !== 1'b1 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, tx_start, 1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || new_q.size() != 0 || sched_busy !== 1'b0 ||
                tx_busy !== 1'b0) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, (n < 3000) && (exp_q.size() == 0), 1);
    endtask

    // Requester model: holds bytes per requester, retires one on req_ready.
    initial begin
        cmd_t c;
        for (int i = 0; i < NUM_REQ; i++) begin
            rhead[i] = 0;
            rcnt[i]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && rcnt[i] > 0) begin
                    rhead[i] = (rhead[i] + 1) % 16;
                    rcnt[i]--;
                end
            end
            while (new_q.size() > 0) begin
                c = new_q.pop_front();
                if (c.op == 0) begin
                    rbuf[c.idx][(rhead[c.idx] + rcnt[c.idx]) % 16] = c.data;
                    rcnt[c.idx]++;
                end else begin
                    rcnt[c.idx] = 0;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i]      = (rcnt[i] > 0);
                req_data[8*i +: 8] = (rcnt[i] > 0) ? rbuf[i][rhead[i]] : 8'h00;
            end
        end
    end

    // UART model: after tx_start, busy rises after 1..3 cycles for 1..8 cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_auto && tx_start) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                uart_busy = 1'b1;
                repeat ($urandom_range(1, 8)) @(negedge clk);
                uart_busy = 1'b0;
            end
        end
    end

    // Scoreboard monitor: pops an expectation on every grant pulse and
    // checks tx_data stays put between grants.
    initial begin
        logic [EW-1:0]      e;
        logic [NUM_REQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                hold_data = 8'h00;
            end
            if (tx_start || req_ready != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: req_ready=%b tx_start=%b tx_data=%0h, expected no grant",
                             req_ready, tx_start, tx_data);
                    hold_data = tx_data;
                end else begin
                    e  = exp_q.pop_front();
                    oh = '0;
                    oh[e[10:8]] = 1'b1;
                    check("grant_ready", req_ready, oh);
                    check("grant_start", tx_start, 1);
                    check("grant_owner", cur_owner, e[10:8]);
                    check("grant_data", tx_data, e[7:0]);
                    grant_log.push_back(int'(e[10:8]));
                    hold_data = e[7:0];
                end
            end else begin
                check("tx_data_hold", tx_data, hold_data);
            end
        end
    end

    // Global time limit
    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "time limit");
    end

    // Directed scenarios, then randomized batches
    initial begin
        int         bad;
        int         mask;
        cmd_t       c;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single request from requester 2, hand-driven busy profile
        clear_batch();
        b_cnt[2] = 1; b_dat[2][0] = 8'hA5;
        issue_batch();
        @(negedge clk); #1;
        check("single_no_early_start", tx_start, 0);
        @(negedge clk); #1;
        check("single_tx_start", tx_start, 1);
        check("single_req_ready", req_ready, 4'b0100);
        check("single_tx_data", tx_data, 8'hA5);
        @(negedge clk); #1;
        man_busy = 1'b1;
        check("single_pulse_one_cycle", {tx_start, req_ready}, 0);
        repeat (10) @(negedge clk);
        #1;
        check("single_busy_while_uart", sched_busy, 1);
        man_busy = 1'b0;
        @(negedge clk); #1;
        check("single_busy_fall", sched_busy, 0);

        // Reset while waiting for the UART to finish
        clear_batch();
        b_cnt[2] = 1; b_dat[2][0] = 8'h3C;
        issue_batch();
        wait_start("rstmid_start");
        @(negedge clk); #1;
        man_busy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rstmid_busy_before", sched_busy, 1);
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        model_last = NUM_REQ - 1;
        check_reset_outputs("rstmid");
        grant_log.delete();
        clear_batch();
        b_cnt[0] = 1; b_dat[0][0] = 8'h11;
        b_cnt[3] = 1; b_dat[3][0] = 8'h33;
        issue_batch();
        repeat (4) @(negedge clk);
        #1;
        check("rstmid_hold_off", req_ready, 0);
        uart_auto = 1'b1;
        man_busy  = 1'b0;
        wait_drain("rstmid_drain");
        check("rstmid_log_size", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("rstmid_first_owner", grant_log[0], 0);
            check("rstmid_second_owner", grant_log[1], 3);
        end

        // All four requesters continuously valid for eight transfers
        grant_log.delete();
        clear_batch();
        for (int i = 0; i < NUM_REQ; i++) begin
            b_cnt[i] = 2;
            b_dat[i][0] = 8'($urandom);
            b_dat[i][1] = 8'($urandom);
        end
        issue_batch();
        wait_drain("rr_drain");
        check("rr_log_size", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size(); i++) begin
            check($sformatf("rr_order_%0d", i), grant_log[i], i % NUM_REQ);
        end

        // Requester 1 withdraws before it can be granted
        grant_log.delete();
        man_busy = 1'b1;
        c.op = 0; c.idx = 1; c.data = 8'h77;
        new_q.push_back(c);
        clear_batch();
        b_cnt[3] = 1; b_dat[3][0] = 8'h99;
        issue_batch();
        repeat (3) @(negedge clk);
        #1;
        c.op = 1; c.idx = 1; c.data = 8'h00;
        new_q.push_back(c);
        repeat (2) @(negedge clk);
        #1;
        check("drop_no_grant_while_busy", req_ready, 0);
        man_busy = 1'b0;
        wait_drain("drop_drain");
        check("drop_log_size", grant_log.size(), 1);
        if (grant_log.size() == 1) begin
            check("drop_owner", grant_log[0], 3);
        end

        // Foreign use of the transmitter blocks grants
        man_busy = 1'b1;
        clear_batch();
        b_cnt[0] = 1; b_dat[0][0] = 8'h5A;
        issue_batch();
        bad = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (req_ready !== '0 || tx_start !== 1'b0) bad++;
        end
        check("foreign_no_grant", bad, 0);
        man_busy = 1'b0;
        @(negedge clk); #1;
        check("foreign_grant_next_cycle", {tx_start, req_ready}, 5'b1_0001);
        wait_drain("foreign_drain");

        // Randomized batches with random UART timing
        for (int t = 0; t < 25; t++) begin
            clear_batch();
            mask = $urandom_range(1, 15);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (mask[i]) begin
                    b_cnt[i] = $urandom_range(1, 3);
                    for (int j = 0; j < 4; j++) begin
                        b_dat[i][j] = 8'($urandom);
                    end
                end
            end
            issue_batch();
            wait_drain($sformatf("rand_drain_%0d", t));
        end

        // UART never reports busy after tx_start
        uart_auto = 1'b0;
        man_busy  = 1'b0;
        clear_batch();
        b_cnt[1] = 1; b_dat[1][0] = 8'hC3;
        issue_batch();
        wait_start("to_start");
`ifdef UART_SCHED_TIMEOUT_EN
        repeat (5) @(negedge clk);
        #1;
        check("to_no_err_before_limit", timeout_err, 0);
        check("to_busy_before_limit", sched_busy, 1);
        @(negedge clk); #1;
        check("to_err_set", timeout_err, 1);
        check("to_back_idle", sched_busy, 0);
        repeat (20) @(negedge clk);
        #1;
        check("to_err_sticky", timeout_err, 1);
        do_reset();
        check("to_err_cleared", timeout_err, 0);
`else
        bad = 0;
        repeat (1000) begin
            @(negedge clk); #1;
            if (sched_busy !== 1'b1) bad++;
        end
        check("to_off_busy_held", bad, 0);
        check("to_off_no_err", timeout_err, 0);
        do_reset();
        check_reset_outputs("to_off_reset");
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
